// File: rtl/symm_mac_seq_if.sv
// Handshake and memory-bus bundle between the SYMM job host and the MAC sequencer.
// The host (master) starts jobs and acknowledges result writes; the sequencer (slave) drives the bus.
interface symm_mac_seq_if #(
    parameter int NMAX = 8,
    parameter int IW   = 3,
    parameter int AW   = 6
);
    logic          start;
    logic [IW:0]   n_dim;
    logic          y_ready;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          mac_last;
    logic          c_rd;
    logic [AW-1:0] c_addr;
    logic          y_we;
    logic [AW-1:0] y_addr;

    modport master (
        output start, n_dim, y_ready,
        input  busy, done, rd_en, a_addr, b_addr, mac_en, mac_clr, mac_last,
               c_rd, c_addr, y_we, y_addr
    );

    modport slave (
        input  start, n_dim, y_ready,
        output busy, done, rd_en, a_addr, b_addr, mac_en, mac_clr, mac_last,
               c_rd, c_addr, y_we, y_addr
    );
endinterface

// File: rtl/symm_mac_seq.sv
// Sequencer for Y = alpha*A*B + beta*C: walks (i,j) row-major, issues N A/B read pairs,
// a C read and a handshaked result write per element; A reads fold into the stored upper triangle.
module symm_mac_seq #(
    parameter int NMAX = 8,
    parameter int IW   = 3,
    parameter int AW   = 6
) (
    input  logic           clk,
    input  logic           rst,
    symm_mac_seq_if.slave  bus
);
    // IDLE: wait start | ISSUE: A/B read k | WAIT: C read | WRITE: result handshake | DONE: end pulse
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [IW:0]   n_q, n_d, n_clamp;
    logic          mac_en_q, mac_en_d;
    logic          mac_clr_q, mac_clr_d;
    logic          mac_last_q, mac_last_d;
    logic          k_last, j_last, i_last;
    logic          rd_en_w, c_rd_w, y_we_w;
    logic [IW-1:0] a_row, a_col;
    logic [AW-1:0] ij_addr;

    assign n_clamp = (bus.n_dim > (IW+1)'(NMAX)) ? (IW+1)'(NMAX) : bus.n_dim;
    assign k_last  = ({1'b0, k_q} == n_q - (IW+1)'(1));
    assign j_last  = ({1'b0, j_q} == n_q - (IW+1)'(1));
    assign i_last  = ({1'b0, i_q} == n_q - (IW+1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            n_q        <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            n_q        <= n_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            mac_last_q <= mac_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        n_d        = n_q;
        mac_en_d   = 1'b0;
        mac_clr_d  = 1'b0;
        mac_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d     = n_clamp;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = (n_clamp == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Operand memories answer one cycle later, so the MAC strobes are registered copies.
                mac_en_d   = 1'b1;
                mac_clr_d  = (k_q == '0);
                mac_last_d = k_last;
                if (k_last) begin
                    k_d     = '0;
                    state_d = WAIT;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            WAIT: state_d = WRITE;
            WRITE: begin
                if (bus.y_ready) begin
                    if (j_last) begin
                        j_d = '0;
                        if (i_last) begin
                            state_d = DONE;
                        end else begin
                            i_d     = i_q + IW'(1);
                            state_d = ISSUE;
                        end
                    end else begin
                        j_d     = j_q + IW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_en_w = (state_q == ISSUE);
    assign c_rd_w  = (state_q == WAIT);
    assign y_we_w  = (state_q == WRITE);

    assign a_row   = (i_q < k_q) ? i_q : k_q;
    assign a_col   = (i_q < k_q) ? k_q : i_q;
    assign ij_addr = AW'(i_q) * AW'(NMAX) + AW'(j_q);

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.rd_en    = rd_en_w;
    assign bus.a_addr   = rd_en_w ? AW'(a_row) * AW'(NMAX) + AW'(a_col) : '0;
    assign bus.b_addr   = rd_en_w ? AW'(k_q) * AW'(NMAX) + AW'(j_q) : '0;
    assign bus.mac_en   = mac_en_q;
    assign bus.mac_clr  = mac_clr_q;
    assign bus.mac_last = mac_last_q;
    assign bus.c_rd     = c_rd_w;
    assign bus.c_addr   = c_rd_w ? ij_addr : '0;
    assign bus.y_we     = y_we_w;
    assign bus.y_addr   = y_we_w ? ij_addr : '0;
endmodule

// File: doc/symm_mac_seq.md
Name: symm_mac_seq

Overview:
- Sequencer for the SYMM multiply-accumulate datapath, which computes Y = alpha*A*B + beta*C.
- Walks output elements (i,j) in row-major order. For each element it issues N inner-product read pairs A(i,k)/B(k,j) to the operand memories and drives the MAC enables/clear/last strobes.
- Issues the C read, then writes the finished element to the result store under a ready handshake.
- A is symmetric and only its upper triangle is stored, so the sequencer folds every A index into the upper triangle.

Parameters:
- NMAX, 8, maximum matrix dimension; memory row stride.
- IW, 3, index width = clog2(NMAX).
- AW, 6, address width = 2*IW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- n_dim  in  IW+1  job dimension; latched on start
- y_ready  in  1  result store accepts write
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse at job end
- rd_en  out  1  A/B read strobe, with a_addr and b_addr valid
- a_addr  out  AW  min(i,k)*NMAX + max(i,k)
- b_addr  out  AW  k*NMAX + j
- mac_en  out  1  accumulate this cycle (rd_en delayed 1)
- mac_clr  out  1  with mac_en, first term (k=0): load instead of add
- mac_last  out  1  with mac_en, last term (k=n-1)
- c_rd  out  1  C read strobe, with c_addr valid
- c_addr  out  AW  i*NMAX + j
- y_we  out  1  result write request
- y_addr  out  AW  i*NMAX + j

Behaviour:
- Reset (async, any state): state=IDLE, i=j=k=0; every output 0, including addresses.
- Dimension latch: n = min(n_dim, NMAX), latched in the IDLE cycle where start=1.
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - start=1 and n=0 -> DONE.
  - start=1 and n>0 -> ISSUE with i=j=k=0.
- ISSUE:
  - rd_en=1 with addresses for the current (i,j,k).
  - If k<n-1, k++. If k=n-1, k<=0 and go to WAIT.
- WAIT: single cycle. c_rd=1, c_addr valid. The last delayed mac_en fires this cycle.
- WRITE:
  - y_we=1 and y_addr are held stable until y_ready=1; y_we stays asserted while y_ready=0.
  - On handshake: if j<n-1, j++ -> ISSUE.
  - Else j<=0; if i<n-1, i++ -> ISSUE; else -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy is high in ISSUE, WAIT, WRITE and DONE.
- Memory latency: operand memories have 1-cycle read latency.
  - mac_en, mac_clr and mac_last are registered copies of rd_en, (k==0) and (k==n-1) from the issuing cycle.
  - The n=1 element asserts mac_clr and mac_last together.
- Per-element cost: N+2 cycles with y_ready=1.
  - Total job: with y_ready=1, done is high in the (n*n*(n+2)+1)th cycle after the start-sampling edge.
  - Each y_ready=0 cycle in WRITE adds one cycle.
- Upper-triangle fold: a_addr always has row<=col. When i==k it is the diagonal i*NMAX+i.
- start while busy: ignored, no effect on counters; n_dim is not re-latched.
- n_dim>NMAX: clamped to NMAX.
- Reset mid-job: everything is aborted immediately; no done pulse. The next start begins cleanly.
- Counter and address widths:
  - Counters are IW bits; the n comparison is IW+1 bits.
  - Addresses are computed without truncation for n<=NMAX.

Test Plan:
- N=2, NMAX=8, y_ready=1, start pulse:
  - a_addr sequence is 0,1,1,9 for element (0,0)/(0,0),(0,1)... exactly a_addr = 0,1, 0,1, 1,9, 1,9.
  - b_addr = 0,8, 1,9, 0,8, 1,9.
  - y_addr = 0,1,8,9.
  - done in cycle 17; busy high cycles 1-17.
- N=3, check fold: element i=2, k=0 gives a_addr=0*8+2=2; element i=1, k=2 gives 10; mac_clr/mac_last align with the 1st/3rd mac_en of each element.
- N=2 with y_ready=0 for 3 cycles on the first write: y_we and y_addr=0 held for 4 cycles; done delayed to cycle 20; no extra rd_en.
- n_dim=0: done pulses in cycle 1; rd_en, mac_en and y_we never assert. n_dim=12: behaves as n=8, with 64 y_we handshakes and done in cycle 641.
- start asserted during busy: no restart, addresses unaffected. rst asserted in ISSUE of element (1,0): all outputs 0 the same cycle, no done; a new start reproduces the full N=2 sequence.
- N=1: one rd_en (a=0, b=0); mac_en with mac_clr=mac_last=1; c_rd then y_we at address 0; done in cycle 4.
